// File: rtl/pool1_cu.sv
// Control unit for the 2x2/stride-2 pooling stage: window-ordered reads from the
// conv ping-pong memory, datapath strobes, and ping-pong writes with handoff.
module pool1_cu #(
  parameter int DATA_WIDTH            = 32,
  parameter int IFM_SIZE              = 30,
  parameter int POOL_SIZE             = 2,
  parameter int READ_LATENCY          = 1,
  parameter int DATAPATH_LATENCY      = 1,
  parameter int IFM_SIZE_NEXT         = IFM_SIZE / 2,
  parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_from_previous,
  output logic                             end_to_previous,
  input  logic                             end_from_next,
  output logic                             start_to_next,
  output logic                             ifm_enable_read_current,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_current,
  output logic                             ifm_sel_current,
  output logic                             pool_first,
  output logic                             pool_enable,
  output logic                             ifm_enable_write_next,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
  output logic                             ifm_sel_next,
  output logic                             ready
);

  localparam int NOUT = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
  localparam int CW   = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
  localparam int WL   = READ_LATENCY + DATAPATH_LATENCY;
  localparam int DCW  = (WL > 0) ? $clog2(WL + 1) : 1;
  localparam int AW   = ADDRESS_SIZE_IFM;
  localparam int WA   = ADDRESS_SIZE_NEXT_IFM;

  generate
    if (POOL_SIZE != 2 || (IFM_SIZE % 2) != 0 || READ_LATENCY < 1 ||
        DATAPATH_LATENCY < 0 || DATA_WIDTH < 1) begin : g_bad_cfg
      $error("pool1_cu: unsupported configuration");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, POOL, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [1:0]      smp;
  logic [CW-1:0]   wcol, wrow;
  logic [AW-1:0]   base, offset;
  logic [DCW-1:0]  dcnt;
  logic [WA-1:0]   waddr;
  logic            out_full, sel_cur, sel_nxt;
  logic            last_col, last_row, last_rd, accept, rd_en, smp0, smp3;

  logic [READ_LATENCY:1] en_pipe, first_pipe;
  logic [WL:1]           wr_pipe;

  assign last_col = (wcol == CW'(IFM_SIZE_NEXT - 1));
  assign last_row = (wrow == CW'(IFM_SIZE_NEXT - 1));
  assign rd_en    = (state == POOL);
  assign smp0     = rd_en && (smp == 2'd0);
  assign smp3     = rd_en && (smp == 2'd3);
  assign last_rd  = smp3 && last_col && last_row;

  assign end_to_previous = (state == IDLE) && !out_full;
  assign accept          = start_from_previous && end_to_previous;
  assign start_to_next   = out_full && end_from_next;
  assign ready           = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = POOL;
      POOL:    if (last_rd) state_nxt = DRAIN;
      DRAIN:   if (dcnt == DCW'(WL)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sample offset inside the current 2x2 window: (0,0) (0,1) (1,0) (1,1).
  always_comb begin
    offset = '0;
    case (smp)
      2'd0: offset = '0;
      2'd1: offset = AW'(1);
      2'd2: offset = AW'(IFM_SIZE);
      2'd3: offset = AW'(IFM_SIZE + 1);
      default: offset = '0;
    endcase
  end

  assign ifm_address_read_current = base + offset;
  assign ifm_enable_read_current  = rd_en;
  assign ifm_sel_current          = sel_cur;

  // Window walk; base skips the odd row at the end of each window row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp     <= '0;
      wcol    <= '0;
      wrow    <= '0;
      base    <= '0;
      dcnt    <= '0;
      sel_cur <= 1'b0;
    end else begin
      if (rd_en) begin
        smp <= smp + 2'd1;
        if (smp == 2'd3) begin
          if (last_col) begin
            wcol <= '0;
            if (last_row) begin
              wrow <= '0;
              base <= '0;
            end else begin
              wrow <= wrow + CW'(1);
              base <= base + AW'(2 + IFM_SIZE);
            end
          end else begin
            wcol <= wcol + CW'(1);
            base <= base + AW'(2);
          end
        end
      end
      if (state == DRAIN) dcnt <= dcnt + DCW'(1);
      else                dcnt <= '0;
      if (last_rd) sel_cur <= !sel_cur;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_pipe    <= '0;
      first_pipe <= '0;
      wr_pipe    <= '0;
    end else begin
      en_pipe[1]    <= rd_en;
      first_pipe[1] <= smp0;
      wr_pipe[1]    <= smp3;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        en_pipe[i]    <= en_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
      end
      for (int i = 2; i <= WL; i++) wr_pipe[i] <= wr_pipe[i-1];
    end
  end

  assign pool_enable           = en_pipe[READ_LATENCY];
  assign pool_first            = first_pipe[READ_LATENCY];
  assign ifm_enable_write_next = wr_pipe[WL];

  // out_full only sets while clear (no map accepted when full), so set/clear never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waddr    <= '0;
      out_full <= 1'b0;
      sel_nxt  <= 1'b0;
    end else begin
      if (start_to_next) begin
        out_full <= 1'b0;
        sel_nxt  <= !sel_nxt;
      end
      if (wr_pipe[WL]) begin
        if (waddr == WA'(NOUT - 1)) begin
          waddr    <= '0;
          out_full <= 1'b1;
        end else begin
          waddr <= waddr + WA'(1);
        end
      end
    end
  end

  assign ifm_address_write_next = waddr;
  assign ifm_sel_next           = sel_nxt;

endmodule

// File: tb/tb_pool1_cu.sv
// Scoreboard bench for pool1_cu: a 4x4 instance for sequencing/handoff and a
// default 30x30 instance for full-size counts.
module tb_pool1_cu;

  logic clk = 1'b0;
  always #5 clk = !clk;

  int checks = 0;
  int errors = 0;

  typedef struct {int addr; int cyc;} ev_t;
  ev_t q_rd[$];
  ev_t q_wr[$];
  int  q_pf[$];

  // 4x4 instance
  logic       reset, start, efn;
  logic       e2p, s2n, rd_en, sel_cur, pfirst, pen, wr_en, sel_next, rdy;
  logic [3:0] rd_addr;
  logic [1:0] wr_addr;

  pool1_cu #(.DATA_WIDTH(32), .IFM_SIZE(4), .POOL_SIZE(2),
             .READ_LATENCY(1), .DATAPATH_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start_from_previous(start),
    .end_to_previous(e2p), .end_from_next(efn), .start_to_next(s2n),
    .ifm_enable_read_current(rd_en), .ifm_address_read_current(rd_addr),
    .ifm_sel_current(sel_cur), .pool_first(pfirst), .pool_enable(pen),
    .ifm_enable_write_next(wr_en), .ifm_address_write_next(wr_addr),
    .ifm_sel_next(sel_next), .ready(rdy));

  // default 30x30 instance
  logic       reset30, start30, efn30;
  logic       e2p30, s2n30, rd_en30, sel_cur30, pfirst30, pen30, wr_en30, sel_next30, rdy30;
  logic [9:0] rd_addr30;
  logic [7:0] wr_addr30;

  pool1_cu dut30 (
    .clk(clk), .reset(reset30), .start_from_previous(start30),
    .end_to_previous(e2p30), .end_from_next(efn30), .start_to_next(s2n30),
    .ifm_enable_read_current(rd_en30), .ifm_address_read_current(rd_addr30),
    .ifm_sel_current(sel_cur30), .pool_first(pfirst30), .pool_enable(pen30),
    .ifm_enable_write_next(wr_en30), .ifm_address_write_next(wr_addr30),
    .ifm_sel_next(sel_next30), .ready(rdy30));

  // One start pulse at cycle 0, then 22 cycles of scoreboard checking.
  task automatic run_map(input bit acc, input bit sel_exp,
                         output int n_s2n, output int s2n_cyc, output int e2p_cyc);
    ev_t e, g;
    int w, pf;
    bit pen_exp;
    q_rd.delete(); q_wr.delete(); q_pf.delete();
    if (acc) begin
      w = 0;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          for (int s = 0; s < 4; s++) begin
            e.addr = (2*r + s/2)*4 + 2*c + s%2;
            e.cyc  = 1 + 4*w + s;
            q_rd.push_back(e);
          end
          q_pf.push_back(2 + 4*w);
          e.addr = w; e.cyc = 6 + 4*w;
          q_wr.push_back(e);
          w++;
        end
    end
    n_s2n = 0; s2n_cyc = -1; e2p_cyc = -1;
    @(negedge clk); start = 1'b1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en) begin
        checks++;
        if (q_rd.size() == 0) begin
          errors++; $display("FAIL extra_read cyc=%0d addr=%0d expected no read", cyc, rd_addr);
        end else begin
          g = q_rd.pop_front();
          if (rd_addr !== 4'(g.addr) || cyc != g.cyc || sel_cur !== sel_exp) begin
            errors++;
            $display("FAIL read cyc=%0d addr=%0d sel=%0d expected cyc=%0d addr=%0d sel=%0d",
                     cyc, rd_addr, sel_cur, g.cyc, g.addr, sel_exp);
          end
        end
      end
      if (pfirst) begin
        checks++;
        if (q_pf.size() == 0) begin
          errors++; $display("FAIL extra_pool_first cyc=%0d", cyc);
        end else begin
          pf = q_pf.pop_front();
          if (cyc != pf) begin
            errors++; $display("FAIL pool_first cyc=%0d expected cyc=%0d", cyc, pf);
          end
        end
      end
      pen_exp = acc && cyc >= 2 && cyc <= 17;
      checks++;
      if (pen !== pen_exp) begin
        errors++; $display("FAIL pool_enable cyc=%0d got=%0b expected=%0b", cyc, pen, pen_exp);
      end
      if (wr_en) begin
        checks++;
        if (q_wr.size() == 0) begin
          errors++; $display("FAIL extra_write cyc=%0d addr=%0d", cyc, wr_addr);
        end else begin
          g = q_wr.pop_front();
          if (wr_addr !== 2'(g.addr) || cyc != g.cyc) begin
            errors++;
            $display("FAIL write cyc=%0d addr=%0d expected cyc=%0d addr=%0d",
                     cyc, wr_addr, g.cyc, g.addr);
          end
        end
      end
      if (s2n) begin n_s2n++; if (s2n_cyc < 0) s2n_cyc = cyc; end
      if (e2p && e2p_cyc < 0) e2p_cyc = cyc;
    end
    checks++;
    if (q_rd.size() != 0 || q_wr.size() != 0 || q_pf.size() != 0) begin
      errors++;
      $display("FAIL missing_events reads=%0d writes=%0d firsts=%0d expected 0 0 0",
               q_rd.size(), q_wr.size(), q_pf.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; start = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; efn = 1'b0;
    reset30 = 1'b1; start30 = 1'b0; efn30 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0; reset30 = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_en, rd_addr, sel_cur, pfirst, pen, wr_en, wr_addr, sel_next, s2n} !== 12'b0 ||
        e2p !== 1'b1 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state outs=%b e2p=%0b rdy=%0b expected outs=0 e2p=1 rdy=1",
               {rd_en, rd_addr, sel_cur, pfirst, pen, wr_en, wr_addr, sel_next, s2n}, e2p, rdy);
    end
  endtask

  task automatic test_address_sequence();
    int n, sc, ec;
    efn = 1'b1;
    run_map(1'b1, 1'b0, n, sc, ec);
    checks++;
    if (n != 1 || sc != 19) begin
      errors++; $display("FAIL handoff pulses=%0d cyc=%0d expected 1 at 19", n, sc);
    end
    checks++;
    if (ec != 20) begin
      errors++; $display("FAIL e2p_rise cyc=%0d expected 20", ec);
    end
    checks++;
    if (sel_next !== 1'b1 || sel_cur !== 1'b1 || rd_addr !== 4'd0) begin
      errors++;
      $display("FAIL banks sel_next=%0b sel_cur=%0b rd_addr=%0d expected 1 1 0",
               sel_next, sel_cur, rd_addr);
    end
  endtask

  task automatic test_backpressure();
    int n, sc, ec;
    do_reset();
    efn = 1'b0;
    run_map(1'b1, 1'b0, n, sc, ec);
    checks++;
    if (n != 0 || e2p !== 1'b0 || rdy !== 1'b1) begin
      errors++; $display("FAIL stall pulses=%0d e2p=%0b rdy=%0b expected 0 0 1", n, e2p, rdy);
    end
    run_map(1'b0, 1'b1, n, sc, ec);
    checks++;
    if (n != 0 || ec != -1) begin
      errors++; $display("FAIL ignored_start pulses=%0d e2p_cyc=%0d expected 0 -1", n, ec);
    end
    @(negedge clk); efn = 1'b1;
    #1;
    checks++;
    if (s2n !== 1'b1 || sel_next !== 1'b0) begin
      errors++; $display("FAIL release s2n=%0b sel_next=%0b expected 1 0", s2n, sel_next);
    end
    @(negedge clk);
    checks++;
    if (s2n !== 1'b0 || e2p !== 1'b1 || sel_next !== 1'b1) begin
      errors++;
      $display("FAIL after_release s2n=%0b e2p=%0b sel_next=%0b expected 0 1 1", s2n, e2p, sel_next);
    end
    run_map(1'b1, 1'b1, n, sc, ec);
    checks++;
    if (n != 1 || sc != 19 || sel_next !== 1'b0 || sel_cur !== 1'b0) begin
      errors++;
      $display("FAIL second_map pulses=%0d cyc=%0d sel_next=%0b sel_cur=%0b expected 1 19 0 0",
               n, sc, sel_next, sel_cur);
    end
  endtask

  task automatic test_back_to_back();
    int n, sc, ec;
    bit sc0, sn0;
    efn = 1'b1;
    for (int m = 0; m < 2; m++) begin
      sc0 = sel_cur; sn0 = sel_next;
      run_map(1'b1, sc0, n, sc, ec);
      checks++;
      if (n != 1 || sc != 19 || sel_cur !== !sc0 || sel_next !== !sn0) begin
        errors++;
        $display("FAIL b2b map=%0d pulses=%0d cyc=%0d sel_cur=%0b sel_next=%0b expected 1 19 %0b %0b",
                 m, n, sc, sel_cur, sel_next, !sc0, !sn0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, sc, ec;
    efn = 1'b1;
    @(negedge clk); start = 1'b1;
    for (int cyc = 1; cyc < 8; cyc++) begin
      @(negedge clk); start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 4'd7) begin
      errors++; $display("FAIL pre_reset rd_en=%0b addr=%0d expected 1 7", rd_en, rd_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({rd_en, rd_addr, sel_cur, pfirst, pen, wr_en, wr_addr, sel_next, s2n} !== 12'b0 ||
        e2p !== 1'b1 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset outs=%b e2p=%0b rdy=%0b expected outs=0 e2p=1 rdy=1",
               {rd_en, rd_addr, sel_cur, pfirst, pen, wr_en, wr_addr, sel_next, s2n}, e2p, rdy);
    end
    @(negedge clk); @(negedge clk); reset = 1'b0;
    @(negedge clk);
    run_map(1'b1, 1'b0, n, sc, ec);
    checks++;
    if (n != 1 || sc != 19 || ec != 20) begin
      errors++; $display("FAIL rerun pulses=%0d cyc=%0d e2p_cyc=%0d expected 1 19 20", n, sc, ec);
    end
  endtask

  task automatic test_default();
    int qa[$];
    int nrd = 0, nwr = 0, last_wr = -1, n_s2n = 0, a;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        for (int s = 0; s < 4; s++)
          qa.push_back((2*r + s/2)*30 + 2*c + s%2);
    efn30 = 1'b1;
    @(negedge clk); start30 = 1'b1;
    for (int cyc = 1; cyc <= 910; cyc++) begin
      @(negedge clk); start30 = 1'b0;
      if (rd_en30) begin
        nrd++;
        a = (qa.size() != 0) ? qa.pop_front() : -1;
        checks++;
        if (rd_addr30 !== 10'(a) || a < 0) begin
          errors++; $display("FAIL read30 cyc=%0d addr=%0d expected %0d", cyc, rd_addr30, a);
        end
      end
      if (wr_en30) begin
        checks++;
        if (wr_addr30 !== 8'(nwr)) begin
          errors++; $display("FAIL write30 cyc=%0d addr=%0d expected %0d", cyc, wr_addr30, nwr);
        end
        last_wr = wr_addr30;
        nwr++;
      end
      if (s2n30) n_s2n++;
    end
    checks++;
    if (nrd != 900 || nwr != 225 || last_wr != 224 || wr_addr30 !== 8'd0 || n_s2n != 1) begin
      errors++;
      $display("FAIL counts30 reads=%0d writes=%0d last=%0d wrap=%0d pulses=%0d expected 900 225 224 0 1",
               nrd, nwr, last_wr, wr_addr30, n_s2n);
    end
    checks++;
    if (rd_addr30 !== 10'd0 || sel_cur30 !== 1'b1 || sel_next30 !== 1'b1 || e2p30 !== 1'b1) begin
      errors++;
      $display("FAIL end30 rd_addr=%0d sel_cur=%0b sel_next=%0b e2p=%0b expected 0 1 1 1",
               rd_addr30, sel_cur30, sel_next30, e2p30);
    end
  endtask

  initial begin
    test_reset();
    test_address_sequence();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_default();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
